// File: rtl/fifo_occ_if.sv
// Handshake and status bundle for the fifo_occ router input-port buffer.
// master drives writes/reads; slave is the FIFO itself.
interface fifo_occ_if #(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned FIFO_DEPTH_WIDTH = 2
);
  logic                        wr_en_i;
  logic                        rd_en_i;
  logic [DATA_WIDTH-1:0]       data_i;
  logic [DATA_WIDTH-1:0]       data_o;
  logic                        full_o;
  logic                        empty_o;
  logic                        almost_full_o;
  logic                        almost_empty_o;
  logic [FIFO_DEPTH_WIDTH:0]   count_o;
  logic                        overflow_o;
  logic                        underflow_o;

  modport master (
    output wr_en_i, rd_en_i, data_i,
    input  data_o, full_o, empty_o, almost_full_o, almost_empty_o, count_o,
           overflow_o, underflow_o
  );

  modport slave (
    input  wr_en_i, rd_en_i, data_i,
    output data_o, full_o, empty_o, almost_full_o, almost_empty_o, count_o,
           overflow_o, underflow_o
  );
endinterface

// File: rtl/fifo_occ.sv
// Circular FIFO using all 2**FIFO_DEPTH_WIDTH entries via wrap-bit pointers, with occupancy,
// almost flags and overflow/underflow pulses. Define FIFO_FWFT_EN for first-word-fall-through reads.
module fifo_occ #(
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned FIFO_DEPTH_WIDTH   = 2,
  parameter int unsigned ALMOST_FULL_LEVEL  = 3,
  parameter int unsigned ALMOST_EMPTY_LEVEL = 1,
  parameter int unsigned ID                 = 0
) (
  input logic       clk_i,
  input logic       rst_ni,
  fifo_occ_if.slave bus
);

  localparam int unsigned Depth = 1 << FIFO_DEPTH_WIDTH;
  localparam int unsigned PtrW  = FIFO_DEPTH_WIDTH + 1;
  localparam logic [PtrW-1:0] AfLevel = PtrW'(ALMOST_FULL_LEVEL);
  localparam logic [PtrW-1:0] AeLevel = PtrW'(ALMOST_EMPTY_LEVEL);

  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PtrW-1:0]       count;
  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic                  empty, full;
  logic                  rd_acc, wr_acc;
  logic                  overflow_q, underflow_q;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                 (wr_ptr_q[PtrW-2:0] == rd_ptr_q[PtrW-2:0]);
  assign count = wr_ptr_q - rd_ptr_q;

  // A pop frees a slot in the same edge, so a full FIFO still takes a write alongside a read.
  assign rd_acc = bus.rd_en_i && !empty;
  assign wr_acc = bus.wr_en_i && (!full || rd_acc);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      overflow_q  <= bus.wr_en_i && !wr_acc;
      underflow_q <= bus.rd_en_i && !rd_acc;
      if (wr_acc) begin
        mem_q[wr_ptr_q[PtrW-2:0]] <= bus.data_i;
        wr_ptr_q                  <= wr_ptr_q + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

`ifdef FIFO_FWFT_EN
  assign bus.data_o = empty ? '0 : mem_q[rd_ptr_q[PtrW-2:0]];
`else
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else if (rd_acc) begin
      data_q <= mem_q[rd_ptr_q[PtrW-2:0]];
    end
  end

  assign bus.data_o = data_q;
`endif

  assign bus.full_o         = full;
  assign bus.empty_o        = empty;
  assign bus.count_o        = count;
  assign bus.almost_full_o  = (count >= AfLevel);
  assign bus.almost_empty_o = (count <= AeLevel);
  assign bus.overflow_o     = overflow_q;
  assign bus.underflow_o    = underflow_q;

`ifndef SYNTHESIS
  initial begin
    $display("fifo_occ[%0d]: depth=%0d width=%0d", ID, Depth, DATA_WIDTH);
    if (ALMOST_FULL_LEVEL < 1 || ALMOST_FULL_LEVEL > Depth) begin
      $error("fifo_occ[%0d]: ALMOST_FULL_LEVEL %0d outside 1..%0d", ID, ALMOST_FULL_LEVEL, Depth);
    end
    if (ALMOST_EMPTY_LEVEL >= Depth) begin
      $error("fifo_occ[%0d]: ALMOST_EMPTY_LEVEL %0d outside 0..%0d", ID, ALMOST_EMPTY_LEVEL,
             Depth - 1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_occ.sv
// Self-checking bench for fifo_occ: directed scenarios plus randomized traffic against a
// queue-based reference model. Honours FIFO_FWFT_EN when defined.
module tb_fifo_occ;

  localparam int unsigned DW    = 8;
  localparam int unsigned FDW   = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AF    = 3;
  localparam int unsigned AE    = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fifo_occ_if #(.DATA_WIDTH(DW), .FIFO_DEPTH_WIDTH(FDW)) bus ();

  fifo_occ #(
    .DATA_WIDTH        (DW),
    .FIFO_DEPTH_WIDTH  (FDW),
    .ALMOST_FULL_LEVEL (AF),
    .ALMOST_EMPTY_LEVEL(AE),
    .ID                (0)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;

  // Reference model: contents as a queue, last registered read word, pending pulses.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_data;
  logic          m_ovf, m_unf;

  function automatic logic [DW-1:0] exp_data();
`ifdef FIFO_FWFT_EN
    return (q.size() != 0) ? q[0] : '0;
`else
    return m_data;
`endif
  endfunction

  function automatic logic [FDW:0] exp_count();
    return (FDW + 1)'(q.size());
  endfunction

  task automatic model_clear();
    q.delete();
    m_data = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  // Drive one cycle (entered and left at posedge+1) and advance the model.
  task automatic step(input logic wr, input logic rd, input logic [DW-1:0] d);
    logic rd_acc, wr_acc;
    bus.wr_en_i = wr;
    bus.rd_en_i = rd;
    bus.data_i  = d;
    @(posedge clk);
    #1;
    rd_acc = rd && (q.size() != 0);
    wr_acc = wr && ((q.size() < int'(DEPTH)) || rd_acc);
    m_ovf  = wr && !wr_acc;
    m_unf  = rd && !rd_acc;
    if (rd_acc) m_data = q.pop_front();
    if (wr_acc) q.push_back(d);
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
  endtask

  task automatic apply_reset();
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
    bus.data_i  = '0;
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    model_clear();
    tests_run++;
    if (bus.count_o !== 3'd0 || bus.empty_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_async: count=%0d empty=%b want 0/1", bus.count_o, bus.empty_o);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++;
    if (bus.empty_o !== 1'b1 || bus.full_o !== 1'b0 || bus.count_o !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_state: empty=%b full=%b count=%0d want 1/0/0",
               bus.empty_o, bus.full_o, bus.count_o);
    end
    tests_run++;
    if (bus.data_o !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_data: got %h want 00", bus.data_o);
    end
    tests_run++;
    if (bus.almost_empty_o !== 1'b1 || bus.almost_full_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_almost: ae=%b af=%b want 1/0", bus.almost_empty_o, bus.almost_full_o);
    end
    tests_run++;
    if (bus.overflow_o !== 1'b0 || bus.underflow_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_pulses: ovf=%b unf=%b want 0/0", bus.overflow_o, bus.underflow_o);
    end
  endtask

  task automatic test_fill_overflow();
    step(1'b1, 1'b0, 8'h11);
    step(1'b1, 1'b0, 8'h22);
    tests_run++;
    if (bus.almost_full_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL af_after_2: got %b want 0", bus.almost_full_o);
    end
    step(1'b1, 1'b0, 8'h33);
    tests_run++;
    if (bus.almost_full_o !== 1'b1 || bus.count_o !== 3'd3) begin
      tests_failed++;
      $display("FAIL af_after_3: af=%b count=%0d want 1/3", bus.almost_full_o, bus.count_o);
    end
    step(1'b1, 1'b0, 8'h44);
    tests_run++;
    if (bus.full_o !== 1'b1 || bus.count_o !== 3'd4) begin
      tests_failed++;
      $display("FAIL full_after_4: full=%b count=%0d want 1/4", bus.full_o, bus.count_o);
    end
    step(1'b1, 1'b0, 8'h55);
    tests_run++;
    if (bus.overflow_o !== 1'b1 || bus.count_o !== 3'd4) begin
      tests_failed++;
      $display("FAIL overflow: ovf=%b count=%0d want 1/4", bus.overflow_o, bus.count_o);
    end
    step(1'b0, 1'b0, 8'h00);
    tests_run++;
    if (bus.overflow_o !== 1'b0 || bus.count_o !== 3'd4) begin
      tests_failed++;
      $display("FAIL overflow_clear: ovf=%b count=%0d want 0/4", bus.overflow_o, bus.count_o);
    end
  endtask

  task automatic test_full_wr_rd();
    step(1'b1, 1'b1, 8'h55);
    tests_run++;
    if (bus.data_o !== exp_data() || bus.count_o !== 3'd4 || bus.overflow_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_wr_rd: data=%h count=%0d ovf=%b want %h/4/0",
               bus.data_o, bus.count_o, bus.overflow_o, exp_data());
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'h00);
      tests_run++;
      if (bus.data_o !== exp_data()) begin
        tests_failed++;
        $display("FAIL drain[%0d]: got %h want %h", i, bus.data_o, exp_data());
      end
    end
    tests_run++;
    if (bus.empty_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL drain_empty: got %b want 1", bus.empty_o);
    end
  endtask

  task automatic test_underflow();
    step(1'b0, 1'b1, 8'h00);
    tests_run++;
    if (bus.underflow_o !== 1'b1 || bus.data_o !== exp_data() || bus.count_o !== 3'd0) begin
      tests_failed++;
      $display("FAIL underflow: unf=%b data=%h count=%0d want 1/%h/0",
               bus.underflow_o, bus.data_o, bus.count_o, exp_data());
    end
    step(1'b0, 1'b0, 8'h00);
    tests_run++;
    if (bus.underflow_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL underflow_clear: got %b want 0", bus.underflow_o);
    end
    step(1'b1, 1'b1, 8'h66);
    tests_run++;
    if (bus.underflow_o !== 1'b1 || bus.count_o !== 3'd1) begin
      tests_failed++;
      $display("FAIL empty_wr_rd: unf=%b count=%0d want 1/1", bus.underflow_o, bus.count_o);
    end
  endtask

  task automatic test_wrap_reset();
    while (q.size() != 0) step(1'b0, 1'b1, 8'h00);
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b0, 8'(i));
      tests_run++;
      if (bus.count_o !== 3'd1) begin
        tests_failed++;
        $display("FAIL wrap_count[%0d]: got %0d want 1", i, bus.count_o);
      end
      step(1'b0, 1'b1, 8'h00);
      tests_run++;
      if (bus.data_o !== exp_data()) begin
        tests_failed++;
        $display("FAIL wrap_data[%0d]: got %h want %h", i, bus.data_o, exp_data());
      end
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
    tests_run++;
    if (bus.count_o !== 3'd3) begin
      tests_failed++;
      $display("FAIL pre_reset_count: got %0d want 3", bus.count_o);
    end
    #1;
    rst_n = 1'b0;
    #1;
    model_clear();
    tests_run++;
    if (bus.count_o !== 3'd0 || bus.empty_o !== 1'b1 || bus.data_o !== 8'h00) begin
      tests_failed++;
      $display("FAIL mid_reset: count=%0d empty=%b data=%h want 0/1/00",
               bus.count_o, bus.empty_o, bus.data_o);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 8'hAA);
    tests_run++;
    if (bus.data_o !== exp_data()) begin
      tests_failed++;
      $display("FAIL post_reset_wr: got %h want %h", bus.data_o, exp_data());
    end
    step(1'b0, 1'b1, 8'h00);
    tests_run++;
    if (bus.data_o !== exp_data()) begin
      tests_failed++;
      $display("FAIL post_reset_rd: got %h want %h", bus.data_o, exp_data());
    end
  endtask

`ifdef FIFO_FWFT_EN
  task automatic test_fwft();
    apply_reset();
    step(1'b1, 1'b0, 8'h5A);
    tests_run++;
    if (bus.data_o !== 8'h5A) begin
      tests_failed++;
      $display("FAIL fwft_show: got %h want 5a", bus.data_o);
    end
    step(1'b0, 1'b1, 8'h00);
    tests_run++;
    if (bus.empty_o !== 1'b1 || bus.data_o !== 8'h00) begin
      tests_failed++;
      $display("FAIL fwft_pop: empty=%b data=%h want 1/00", bus.empty_o, bus.data_o);
    end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45), 8'($urandom));
      tests_run++;
      if (bus.data_o !== exp_data() || bus.count_o !== exp_count()) begin
        tests_failed++;
        $display("FAIL rand_data_count[%0d]: data=%h count=%0d want %h/%0d",
                 n, bus.data_o, bus.count_o, exp_data(), exp_count());
      end
      tests_run++;
      if (bus.full_o !== (q.size() == int'(DEPTH)) || bus.empty_o !== (q.size() == 0) ||
          bus.almost_full_o !== (q.size() >= int'(AF)) ||
          bus.almost_empty_o !== (q.size() <= int'(AE))) begin
        tests_failed++;
        $display("FAIL rand_flags[%0d]: full=%b empty=%b af=%b ae=%b size=%0d",
                 n, bus.full_o, bus.empty_o, bus.almost_full_o, bus.almost_empty_o, q.size());
      end
      tests_run++;
      if (bus.overflow_o !== m_ovf || bus.underflow_o !== m_unf) begin
        tests_failed++;
        $display("FAIL rand_pulses[%0d]: ovf=%b unf=%b want %b/%b",
                 n, bus.overflow_o, bus.underflow_o, m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
    bus.data_i  = '0;
    model_clear();
    test_reset();
    test_fill_overflow();
    test_full_wr_rd();
    test_underflow();
    test_wrap_reset();
`ifdef FIFO_FWFT_EN
    test_fwft();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fifo_occ.md
Name: fifo_occ

Overview:
- Parametrised successor to the basic circular FIFO, used as the router input-port buffer.
- Uses all 2**FIFO_DEPTH_WIDTH entries through an extra wrap bit on each pointer.
- Exposes occupancy count, almost-full and almost-empty flags, and registered overflow/underflow pulses.
- Optional first-word-fall-through (FWFT) read mode, selected at compile time.

Parameters:
- DATA_WIDTH, 8, payload width in bits.
- FIFO_DEPTH_WIDTH, 2, log2 of depth; DEPTH = 2**FIFO_DEPTH_WIDTH.
- ALMOST_FULL_LEVEL, 3, almost_full_o asserts when count >= this value; legal range 1..DEPTH.
- ALMOST_EMPTY_LEVEL, 1, almost_empty_o asserts when count <= this value; legal range 0..DEPTH-1.
- ID, 0, instance tag printed by the initial $display banner.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- wr_en_i  in  1  write request.
- rd_en_i  in  1  read request (registered mode) or pop/acknowledge (FWFT mode).
- data_i  in  DATA_WIDTH  write data.
- data_o  out  DATA_WIDTH  read data.
- full_o  out  1  count == DEPTH.
- empty_o  out  1  count == 0.
- almost_full_o  out  1  count >= ALMOST_FULL_LEVEL.
- almost_empty_o  out  1  count <= ALMOST_EMPTY_LEVEL.
- count_o  out  FIFO_DEPTH_WIDTH+1  occupancy, 0..DEPTH.
- overflow_o  out  1  one-cycle pulse after a rejected write.
- underflow_o  out  1  one-cycle pulse after a rejected read.

Behaviour:
- Pointers:
  - wr_ptr and rd_ptr are FIFO_DEPTH_WIDTH+1 bits wide; the low bits address memory and the MSB is the wrap bit.
  - Both pointers increment modulo 2**(FIFO_DEPTH_WIDTH+1).
  - empty = pointers equal.
  - full = MSBs differ and low bits equal.
  - count_o = wr_ptr - rd_ptr, taken modulo 2**(FIFO_DEPTH_WIDTH+1).
- Flag timing: all flags and count_o are combinational from the registered pointers, so they update the cycle after the accepting edge.
- Read acceptance: rd_acc = rd_en_i && !empty.
- Write acceptance: wr_acc = wr_en_i && (!full || rd_acc).
  - Full with simultaneous wr+rd: both accepted, count unchanged, no overflow.
  - Empty with simultaneous wr+rd: write accepted, read rejected, underflow pulses, count becomes 1.
- Rejected write:
  - Memory and pointers unchanged.
  - overflow_o = 1 for exactly the next cycle, then 0 unless another write is rejected.
- Rejected read:
  - rd_ptr and data_o unchanged.
  - underflow_o = 1 for exactly the next cycle.
- Registered read mode (macro absent):
  - On rd_acc, data_o <= mem[rd_ptr]; read latency is 1 cycle.
  - data_o holds its value when there is no accepted read.
- Reset:
  - rst_ni low clears pointers, all memory entries, data_o, overflow_o and underflow_o immediately, regardless of clock.
  - Resulting outputs: empty_o=1, full_o=0, count_o=0, almost_empty_o=1.
  - almost_full_o=0 for any legal level.
  - This applies equally to reset asserted mid-operation; in-flight data is discarded.
- Parameter check: the initial block prints ID, depth and width, and issues $error if either almost level is outside its legal range.

Optional Feature:
- Macro: FIFO_FWFT_EN.
- Defined (FWFT mode):
  - data_o = mem[rd_ptr] combinationally whenever !empty; data_o = 0 when empty.
  - A word written into an empty FIFO is visible on data_o the cycle after the write edge.
  - rd_en_i pops the shown word; the next word, if any, appears the following cycle.
  - Acceptance and underflow rules are unchanged.
- Undefined: registered read mode as described in Behaviour.

Test Plan:
All scenarios use defaults: DEPTH=4, DATA_WIDTH=8, ALMOST_FULL_LEVEL=3, ALMOST_EMPTY_LEVEL=1.
- Reset:
  - Stimulus: apply reset, then release.
  - Required: empty_o=1, full_o=0, count_o=0, data_o=0x00, almost_empty_o=1, almost_full_o=0, overflow_o=0, underflow_o=0.
- Fill and overflow:
  - Stimulus: write 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
  - Required: almost_full_o rises after the third write; count_o=4 and full_o=1 after the fourth.
  - Stimulus: a fifth write of 0x55.
  - Required: overflow_o=1 for one cycle, count_o stays 4, no data lost.
- Full with simultaneous write and read:
  - Stimulus: while full, assert wr 0x55 and rd together.
  - Required: data_o=0x11 next cycle, count_o=4, overflow_o=0.
  - Stimulus: drain the FIFO.
  - Required: reads return 0x22, 0x33, 0x44, 0x55, then empty_o=1.
- Underflow:
  - Stimulus: read while empty.
  - Required: underflow_o=1 for one cycle, data_o holds 0x55, count_o=0.
  - Stimulus: simultaneous wr 0x66 and rd on empty.
  - Required: underflow_o=1, count_o=1.
- Wrap-around and mid-operation reset:
  - Stimulus: 12 write/read pairs of 0x01..0x0C.
  - Required: values read back in order, count_o never exceeds 1, pointers wrap past 8.
  - Stimulus: assert reset while count_o=3.
  - Required: count_o=0 and empty_o=1 immediately.
  - Stimulus: write 0xAA, then read.
  - Required: data_o=0xAA.
- FWFT (FIFO_FWFT_EN defined):
  - Stimulus: write 0x5A into empty.
  - Required: data_o=0x5A one cycle later with no rd_en_i.
  - Stimulus: assert rd_en_i.
  - Required: empty_o=1 and data_o=0x00 the next cycle.
